jacobi_pivot_sequencer: RTL and testbench

Sequences one Jacobi eigenvalue sweep schedule over the N×N symmetric matrix held in the shared dual-port BRAM. For each pivot pair (p,q) it:
- reads a_pp, a_qq and a_pq,
- drives the vectoring CORDIC to obtain the rotation angle,
- hands (p, q, angle) to the rotation stage,
- waits for that stage to finish writeback before reading the next pair.

It sits inside the Jacobi main controller, between the BRAM read ports and the two CORDIC instances, and repeats the schedule for a fixed number of sweeps.

---
 rtl/common.sv | 24 ++
 rtl/jacobi_pair_counter.sv | 55 +++++
 rtl/jacobi_pivot_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_jacobi_pivot_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared constants and FSM state type for the Jacobi pivot sequencer.
// Imported by the sequencer top and its pair counter.
package common;

    localparam int JACOBI_N                 = 4;
    localparam int JACOBI_OUTPUT_WORD_WIDTH = 16;
    localparam int JACOBI_ADDR_WIDTH        = 4;
    localparam int JACOBI_ANGLE_WIDTH       = 16;
    localparam int JACOBI_SWEEPS            = 6;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RD_DIAG   = 4'd1,
        ST_RD_OFF    = 4'd2,
        ST_CALC      = 4'd3,
        ST_VEC_ISSUE = 4'd4,
        ST_VEC_WAIT  = 4'd5,
        ST_ROT_ISSUE = 4'd6,
        ST_ROT_WAIT  = 4'd7,
        ST_NEXT      = 4'd8,
        ST_DONE      = 4'd9
    } jacobi_seq_state_t;

endpackage

// File: rtl/jacobi_pair_counter.sv
// Cyclic-by-row pivot pair generator: (0,1),(0,2)..(N-2,N-1), then wraps.
// Ports: clk, rst (sync, high), clr (restart at (0,1)), adv (step), p, q, last_pair.
module jacobi_pair_counter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [PW-1:0] p,
    output logic [PW-1:0] q,
    output logic          last_pair
);

    logic [PW-1:0] p_q, p_d;
    logic [PW-1:0] q_q, q_d;

    always_comb begin
        p_d = p_q;
        q_d = q_q;
        if (clr) begin
            p_d = '0;
            q_d = PW'(1);
        end else if (adv) begin
            if (q_q == PW'(N - 1)) begin
                if (p_q == PW'(N - 2)) begin
                    p_d = '0;
                    q_d = PW'(1);
                end else begin
                    // new row starts just right of the diagonal
                    p_d = p_q + PW'(1);
                    q_d = p_q + PW'(1) + PW'(1);
                end
            end else begin
                q_d = q_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            q_q <= PW'(1);
        end else begin
            p_q <= p_d;
            q_q <= q_d;
        end
    end

    assign p         = p_q;
    assign q         = q_q;
    assign last_pair = (p_q == PW'(N - 2)) && (q_q == PW'(N - 1));

endmodule

// File: rtl/jacobi_pivot_sequencer.sv
// Walks the Jacobi pivot schedule: BRAM reads, vectoring CORDIC, rotation handoff.
// Ports: start/busy/done job control, two BRAM read ports, vec_* CORDIC, rot_* stage.
module jacobi_pivot_sequencer
    import common::*;
#(
    parameter int N           = JACOBI_N,
    parameter int WORD_WIDTH  = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int ADDR_WIDTH  = JACOBI_ADDR_WIDTH,
    parameter int ANGLE_WIDTH = JACOBI_ANGLE_WIDTH,
    parameter int SWEEPS      = JACOBI_SWEEPS,
    parameter int PW          = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   ram_en_a_o,
    output logic [ADDR_WIDTH-1:0]  ram_addr_a_o,
    input  logic [WORD_WIDTH-1:0]  ram_dout_a_i,
    output logic                   ram_en_b_o,
    output logic [ADDR_WIDTH-1:0]  ram_addr_b_o,
    input  logic [WORD_WIDTH-1:0]  ram_dout_b_i,
    output logic [WORD_WIDTH:0]    vec_x_o,
    output logic [WORD_WIDTH:0]    vec_y_o,
    output logic [ANGLE_WIDTH-1:0] vec_z_o,
    output logic                   vec_vld_o,
    input  logic [ANGLE_WIDTH-1:0] vec_z_i,
    input  logic                   vec_vld_i,
    output logic [PW-1:0]          rot_p_o,
    output logic [PW-1:0]          rot_q_o,
    output logic [ANGLE_WIDTH-1:0] rot_angle_o,
    output logic                   rot_vld_o,
    input  logic                   rot_rdy_i,
    input  logic                   rot_done_i
);

    localparam int SWW = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;

    jacobi_seq_state_t state_q, state_d;

    logic [SWW-1:0]         sweep_q, sweep_d;
    logic                   wrap_q, wrap_d;
    logic [WORD_WIDTH-1:0]  a_pp_q, a_pp_d;
    logic [WORD_WIDTH-1:0]  a_qq_q, a_qq_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   en_a_q, en_a_d;
    logic                   en_b_q, en_b_d;
    logic [ADDR_WIDTH-1:0]  addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0]  addr_b_q, addr_b_d;
    logic [WORD_WIDTH:0]    vec_x_q, vec_x_d;
    logic [WORD_WIDTH:0]    vec_y_q, vec_y_d;
    logic                   vec_vld_q, vec_vld_d;
    logic [PW-1:0]          rot_p_q, rot_p_d;
    logic [PW-1:0]          rot_q_q, rot_q_d;
    logic [ANGLE_WIDTH-1:0] rot_angle_q, rot_angle_d;
    logic                   rot_vld_q, rot_vld_d;

    logic          pc_clr;
    logic          pc_adv;
    logic [PW-1:0] pc_p;
    logic [PW-1:0] pc_q;
    logic          pc_last;

    jacobi_pair_counter #(
        .N  (N),
        .PW (PW)
    ) u_pairs (
        .clk       (clk),
        .rst       (rst),
        .clr       (pc_clr),
        .adv       (pc_adv),
        .p         (pc_p),
        .q         (pc_q),
        .last_pair (pc_last)
    );

    function automatic logic [ADDR_WIDTH-1:0] addr_of(
        input logic [PW-1:0] r,
        input logic [PW-1:0] c
    );
        return ADDR_WIDTH'(r) * ADDR_WIDTH'(N) + ADDR_WIDTH'(c);
    endfunction

    // The pair counter advances on entry to NEXT, so NEXT already sees the
    // upcoming pair; wrap_q remembers whether the finished pair closed a sweep.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        wrap_d      = wrap_q;
        a_pp_d      = a_pp_q;
        a_qq_d      = a_qq_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        en_a_d      = 1'b0;
        en_b_d      = 1'b0;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        vec_x_d     = vec_x_q;
        vec_y_d     = vec_y_q;
        vec_vld_d   = 1'b0;
        rot_p_d     = rot_p_q;
        rot_q_d     = rot_q_q;
        rot_angle_d = rot_angle_q;
        rot_vld_d   = rot_vld_q;
        pc_clr      = 1'b0;
        pc_adv      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RD_DIAG;
                    pc_clr   = 1'b1;
                    sweep_d  = '0;
                    wrap_d   = 1'b0;
                    busy_d   = 1'b1;
                    en_a_d   = 1'b1;
                    en_b_d   = 1'b1;
                    addr_a_d = addr_of('0, '0);
                    addr_b_d = addr_of(PW'(1), PW'(1));
                end
            end
            ST_RD_DIAG: begin
                state_d  = ST_RD_OFF;
                en_a_d   = 1'b1;
                addr_a_d = addr_of(pc_p, pc_q);
            end
            ST_RD_OFF: begin
                state_d = ST_CALC;
                a_pp_d  = ram_dout_a_i;
                a_qq_d  = ram_dout_b_i;
            end
            ST_CALC: begin
                if (ram_dout_a_i == '0) begin
                    state_d = ST_NEXT;
                    pc_adv  = 1'b1;
                    wrap_d  = pc_last;
                end else begin
                    state_d   = ST_VEC_ISSUE;
                    vec_vld_d = 1'b1;
                    vec_x_d   = {a_qq_q[WORD_WIDTH-1], a_qq_q}
                              - {a_pp_q[WORD_WIDTH-1], a_pp_q};
                    vec_y_d   = {ram_dout_a_i, 1'b0};
                end
            end
            ST_VEC_ISSUE: begin
                state_d = ST_VEC_WAIT;
            end
            ST_VEC_WAIT: begin
                if (vec_vld_i) begin
                    state_d     = ST_ROT_ISSUE;
                    rot_angle_d = $signed(vec_z_i) >>> 1;
                    rot_p_d     = pc_p;
                    rot_q_d     = pc_q;
                    rot_vld_d   = 1'b1;
                end
            end
            ST_ROT_ISSUE: begin
                if (rot_rdy_i) begin
                    state_d   = ST_ROT_WAIT;
                    rot_vld_d = 1'b0;
                end
            end
            ST_ROT_WAIT: begin
                if (rot_done_i) begin
                    state_d = ST_NEXT;
                    pc_adv  = 1'b1;
                    wrap_d  = pc_last;
                end
            end
            ST_NEXT: begin
                if (wrap_q && (sweep_q == SWW'(SWEEPS - 1))) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    if (wrap_q) begin
                        sweep_d = sweep_q + SWW'(1);
                    end
                    state_d  = ST_RD_DIAG;
                    en_a_d   = 1'b1;
                    en_b_d   = 1'b1;
                    addr_a_d = addr_of(pc_p, pc_p);
                    addr_b_d = addr_of(pc_q, pc_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sweep_q     <= '0;
            wrap_q      <= 1'b0;
            a_pp_q      <= '0;
            a_qq_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            en_a_q      <= 1'b0;
            en_b_q      <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            vec_x_q     <= '0;
            vec_y_q     <= '0;
            vec_vld_q   <= 1'b0;
            rot_p_q     <= '0;
            rot_q_q     <= '0;
            rot_angle_q <= '0;
            rot_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            wrap_q      <= wrap_d;
            a_pp_q      <= a_pp_d;
            a_qq_q      <= a_qq_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            en_a_q      <= en_a_d;
            en_b_q      <= en_b_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            vec_x_q     <= vec_x_d;
            vec_y_q     <= vec_y_d;
            vec_vld_q   <= vec_vld_d;
            rot_p_q     <= rot_p_d;
            rot_q_q     <= rot_q_d;
            rot_angle_q <= rot_angle_d;
            rot_vld_q   <= rot_vld_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign ram_en_a_o   = en_a_q;
    assign ram_addr_a_o = addr_a_q;
    assign ram_en_b_o   = en_b_q;
    assign ram_addr_b_o = addr_b_q;
    assign vec_x_o      = vec_x_q;
    assign vec_y_o      = vec_y_q;
    assign vec_z_o      = '0;
    assign vec_vld_o    = vec_vld_q;
    assign rot_p_o      = rot_p_q;
    assign rot_q_o      = rot_q_q;
    assign rot_angle_o  = rot_angle_q;
    assign rot_vld_o    = rot_vld_q;

endmodule

// File: tb/tb_jacobi_pivot_sequencer.sv
// Randomized bench for jacobi_pivot_sequencer with BRAM, CORDIC and rotation models.
// Expected traffic follows the pair schedule walked with plain nested loops.
module tb_jacobi_pivot_sequencer;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int AW  = 4;
    localparam int AGW = 16;
    localparam int SW  = 2;
    localparam int PW  = $clog2(N);
    localparam int P   = N * (N - 1) / 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_i = 1'b0;
    logic           busy_o;
    logic           done_o;
    logic           ram_en_a_o;
    logic [AW-1:0]  ram_addr_a_o;
    logic [W-1:0]   ram_dout_a_i = '0;
    logic           ram_en_b_o;
    logic [AW-1:0]  ram_addr_b_o;
    logic [W-1:0]   ram_dout_b_i = '0;
    logic [W:0]     vec_x_o;
    logic [W:0]     vec_y_o;
    logic [AGW-1:0] vec_z_o;
    logic           vec_vld_o;
    logic [AGW-1:0] vec_z_i = '0;
    logic           vec_vld_i = 1'b0;
    logic [PW-1:0]  rot_p_o;
    logic [PW-1:0]  rot_q_o;
    logic [AGW-1:0] rot_angle_o;
    logic           rot_vld_o;
    logic           rot_rdy_i = 1'b0;
    logic           rot_done_i = 1'b0;

    jacobi_pivot_sequencer #(
        .N           (N),
        .WORD_WIDTH  (W),
        .ADDR_WIDTH  (AW),
        .ANGLE_WIDTH (AGW),
        .SWEEPS      (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ram_en_a_o   (ram_en_a_o),
        .ram_addr_a_o (ram_addr_a_o),
        .ram_dout_a_i (ram_dout_a_i),
        .ram_en_b_o   (ram_en_b_o),
        .ram_addr_b_o (ram_addr_b_o),
        .ram_dout_b_i (ram_dout_b_i),
        .vec_x_o      (vec_x_o),
        .vec_y_o      (vec_y_o),
        .vec_z_o      (vec_z_o),
        .vec_vld_o    (vec_vld_o),
        .vec_z_i      (vec_z_i),
        .vec_vld_i    (vec_vld_i),
        .rot_p_o      (rot_p_o),
        .rot_q_o      (rot_q_o),
        .rot_angle_o  (rot_angle_o),
        .rot_vld_o    (rot_vld_o),
        .rot_rdy_i    (rot_rdy_i),
        .rot_done_i   (rot_done_i)
    );

    always #5 clk = ~clk;

    int mem [N*N];

    always @(posedge clk) begin
        if (ram_en_a_o) ram_dout_a_i <= W'(mem[ram_addr_a_o]);
        if (ram_en_b_o) ram_dout_b_i <= W'(mem[ram_addr_b_o]);
    end

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    bit force_z     = 1'b0;
    int fixed_z     = 0;
    int force_stall = -1;

    task automatic check(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int rand_word();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int floor_half(input int z);
        if (z >= 0) return z / 2;
        return -((-z + 1) / 2);
    endfunction

    task automatic set_sym(input int r, input int c, input int v);
        mem[r*N+c] = v;
        mem[c*N+r] = v;
    endtask

    task automatic fill_identity();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mem[r*N+c] = (r == c) ? 1 : 0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < N; r++) begin
            mem[r*N+r] = rand_word();
            for (int c = r + 1; c < N; c++)
                set_sym(r, c, ($urandom_range(0, 2) == 0) ? 0 : rand_word());
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_done"},  done_o, 0);
        check({tag, "_en"},    {ram_en_a_o, ram_en_b_o}, 0);
        check({tag, "_addr"},  {ram_addr_a_o, ram_addr_b_o}, 0);
        check({tag, "_vec"},   {vec_x_o, vec_y_o, vec_z_o, vec_vld_o}, 0);
        check({tag, "_rot"},   {rot_p_o, rot_q_o, rot_angle_o, rot_vld_o}, 0);
    endtask

    // One complete job; every sampled cycle is predicted from the pair schedule.
    task automatic run_job(input bit poke, input bit timed);
        int app, aqq, apq, z, stall, lat, wt, c0;
        c0 = cyc;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int s = 0; s < SW; s++) begin
            for (int p = 0; p < N - 1; p++) begin
                for (int q = p + 1; q < N; q++) begin
                    check("rd_busy", busy_o, 1);
                    check("rd_diag_en", {ram_en_a_o, ram_en_b_o}, 3);
                    check("rd_diag_addr_a", ram_addr_a_o, p*N+p);
                    check("rd_diag_addr_b", ram_addr_b_o, q*N+q);
                    app = mem[p*N+p];
                    aqq = mem[q*N+q];
                    apq = mem[p*N+q];
                    if (poke && s == 0 && p == 0 && q == 1) start_i = 1'b1;
                    step();
                    start_i = 1'b0;
                    check("rd_off_en", {ram_en_a_o, ram_en_b_o}, 2);
                    check("rd_off_addr", ram_addr_a_o, p*N+q);
                    step();
                    check("calc_en", {ram_en_a_o, ram_en_b_o}, 0);
                    step();
                    if (apq == 0) begin
                        check("skip_vec", vec_vld_o, 0);
                        check("skip_rot", rot_vld_o, 0);
                        check("skip_busy", busy_o, 1);
                    end else begin
                        check("vec_vld", vec_vld_o, 1);
                        check("vec_x", longint'($signed(vec_x_o)), aqq - app);
                        check("vec_y", longint'($signed(vec_y_o)), 2 * apq);
                        check("vec_z", vec_z_o, 0);
                        z = force_z ? fixed_z : rand_word();
                        step();
                        check("vec_pulse", vec_vld_o, 0);
                        lat = $urandom_range(0, 3);
                        repeat (lat) step();
                        vec_vld_i = 1'b1;
                        vec_z_i   = AGW'(z);
                        step();
                        vec_vld_i = 1'b0;
                        vec_z_i   = AGW'($urandom);
                        stall = (force_stall >= 0) ? force_stall
                                                   : $urandom_range(0, 4);
                        for (int k = 0; k <= stall; k++) begin
                            check("rot_vld", rot_vld_o, 1);
                            check("rot_p", rot_p_o, p);
                            check("rot_q", rot_q_o, q);
                            check("rot_angle", longint'($signed(rot_angle_o)),
                                  floor_half(z));
                            if (k < stall) begin
                                rot_done_i = $urandom_range(0, 1) == 1;
                                step();
                                rot_done_i = 1'b0;
                            end
                        end
                        rot_rdy_i = 1'b1;
                        step();
                        rot_rdy_i = 1'b0;
                        check("rot_accepted", rot_vld_o, 0);
                        wt = $urandom_range(0, 3);
                        repeat (wt) begin
                            step();
                            check("rot_wait_rd", {ram_en_a_o, ram_en_b_o}, 0);
                        end
                        mem[p*N+p] = rand_word();
                        mem[q*N+q] = rand_word();
                        set_sym(p, q, ($urandom_range(0, 3) == 0) ? rand_word() : 0);
                        rot_done_i = 1'b1;
                        step();
                        rot_done_i = 1'b0;
                        check("next_busy", busy_o, 1);
                        check("next_en", {ram_en_a_o, ram_en_b_o}, 0);
                    end
                    step();
                end
            end
        end
        check("done_pulse", done_o, 1);
        check("done_busy", busy_o, 0);
        if (timed) check("done_cycle", cyc - c0, 4 * P * SW + 1);
        step();
        check("done_clear", done_o, 0);
        check("idle_busy", busy_o, 0);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        fill_identity();
        run_job(1'b0, 1'b1);

        fill_identity();
        mem[0] = 100;
        mem[N+1] = 300;
        set_sym(0, 1, 50);
        force_z     = 1'b1;
        fixed_z     = 'h1000;
        force_stall = 5;
        run_job(1'b0, 1'b0);
        force_z     = 1'b0;
        force_stall = -1;

        fill_identity();
        mem[0] = 32767;
        mem[N+1] = -32768;
        set_sym(0, 1, -32768);
        run_job(1'b1, 1'b0);

        fill_random();
        set_sym(0, 1, 1234);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midjob_reset");
        vec_vld_i = 1'b1;
        vec_z_i   = AGW'($urandom);
        step();
        vec_vld_i = 1'b0;
        check("stale_vec_busy", busy_o, 0);
        check("stale_vec_rot", rot_vld_o, 0);
        step();
        check_all_zero("stale_idle");
        run_job(1'b0, 1'b0);

        for (int j = 0; j < 6; j++) begin
            fill_random();
            run_job($urandom_range(0, 1) == 1, 1'b0);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
